// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store access stage (lsu_mem_align).
// Holds RV32I load/store funct3 codes, the access size and FSM state types,
// and small decode helpers used by both the FSM and the lane aligner.
package lsu_pkg;

  // RV32I load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Access width
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Access FSM; encodings kept explicit to match the legacy localparam values
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  // funct3[1:0] selects the width; funct3[2] (unsigned) does not affect size
  function automatic size_e size_of(input logic [2:0] funct3);
    size_e sz;
    case (funct3[1:0])
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  // An access is misaligned when its low address bits are not naturally aligned
  function automatic logic is_misaligned(input size_e sz, input logic [1:0] addr_lo);
    logic mis;
    case (sz)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Low address bits forced to natural alignment for the given size
  function automatic logic [1:0] align_lo(input size_e sz, input logic [1:0] addr_lo);
    logic [1:0] lo;
    case (sz)
      SZ_HALF: lo = {addr_lo[1], 1'b0};
      SZ_WORD: lo = 2'b00;
      default: lo = addr_lo;
    endcase
    return lo;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 32-bit data memory (4 byte lanes).
// From access size and byte offset: byte enables, lane-replicated store data,
// right-aligned/zero-masked load data, and the misalignment flag.
// The offset is forced to natural alignment internally, so a misaligned offset
// still yields a well-formed (aligned) lane pattern.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [1:0]  w_off;
  logic [31:0] w_shifted;

  // Effective lane offset and the read word shifted down to bit 0
  always_comb begin
    w_off     = align_lo(i_size, i_addr_lo);
    w_shifted = i_rdata >> {w_off, 3'b000};
  end

  // Per-size lane enables, store replication and load masking
  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    o_rdata = '0;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << w_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {24'd0, w_shifted[7:0]};
      end
      SZ_HALF: begin
        o_be    = 4'b0011 << {w_off[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {16'd0, w_shifted[15:0]};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = w_shifted;
      end
    endcase
  end

  // Misalignment is judged on the raw offset, before forcing
  always_comb begin
    o_misalign = is_misaligned(i_size, i_addr_lo);
  end

endmodule

// File: rtl/lsu_mem_align.sv
// Load/store access stage feeding loads_sign_extend.
// Accepts one access at a time, runs a req/gnt + rvalid handshake to a
// word-addressed data memory, and returns right-aligned load data with the
// original funct3.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- misaligned accesses skip the
// memory and respond at once with rsp_misalign=1; otherwise they are forced
// to natural alignment and proceed.
module lsu_mem_align
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [2:0]            rsp_funct3,
  output logic                  rsp_misalign
);

  state_e                r_state;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_misalign;

  logic                  w_idle;
  size_e                 w_size;
  logic [1:0]            w_addr_lo;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata_rep;
  logic [DATA_WIDTH-1:0] w_rdata_align;
  logic                  w_misalign;
  logic                  w_trap;

  // The single lane aligner looks at the incoming request while IDLE (to
  // judge misalignment at accept) and at the latched access otherwise.
  always_comb begin
    w_idle    = (r_state == ST_IDLE);
    w_size    = size_of(w_idle ? req_funct3 : r_funct3);
    w_addr_lo = w_idle ? req_addr[1:0] : r_addr[1:0];
  end

  lsu_lane_align u_lane (
    .i_size     (w_size),
    .i_addr_lo  (w_addr_lo),
    .i_wdata    (r_wdata),
    .i_rdata    (mem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata_rep),
    .o_rdata    (w_rdata_align),
    .o_misalign (w_misalign)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = w_misalign;
`else
  assign w_trap = 1'b0;
`endif

  // Access FSM plus request/response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_funct3   <= req_funct3;
            r_wdata    <= req_wdata;
            r_rsp_data <= '0;
            // Misaligned low bits are snapped to natural alignment here so the
            // lane aligner later sees an aligned offset.
            r_addr     <= {req_addr[ADDR_WIDTH-1:2],
                           w_misalign ? align_lo(w_size, req_addr[1:0]) : req_addr[1:0]};
            r_misalign <= w_trap;
            r_state    <= w_trap ? ST_RSP : ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            r_state <= r_we ? ST_RSP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_rsp_data <= w_rdata_align;
            r_state    <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory-side outputs are only driven while a request is pending
  always_comb begin
    mem_req   = (r_state == ST_REQ);
    mem_we    = mem_req & r_we;
    mem_addr  = mem_req ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    mem_be    = mem_req ? w_be : '0;
    mem_wdata = mem_req ? w_wdata_rep : '0;
  end

  // Execute/consumer-side handshake and response
  always_comb begin
    req_ready  = w_idle;
    rsp_valid  = (r_state == ST_RSP);
    rsp_data   = r_rsp_data;
    rsp_funct3 = r_funct3;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_misalign = r_misalign;
`else
  assign rsp_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_align.sv
// Self-checking bench for lsu_mem_align: directed cases plus random accesses
// checked against a byte-lane reference model.
module tb_lsu_mem_align;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_funct3;
  logic        rsp_misalign;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  lsu_mem_align #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_funct3   (rsp_funct3),
    .rsp_misalign (rsp_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes from funct3
  function automatic int unsigned nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic trap_en();
`ifdef LSU_MISALIGN_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One full access: drive request, act as memory with the given stalls,
  // hold off the consumer, and check every visible output each cycle.
  task automatic do_access(input string nm, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int unsigned gd,
                           input int unsigned rd, input int unsigned kd);
    int unsigned n, off;
    logic        mis, trap;
    logic [31:0] ebe, ewd, ersp, eaddr;
    n     = nbytes(f3);
    mis   = ((addr % n) != 0);
    trap  = mis & trap_en();
    off   = ((addr % 4) / n) * n;
    eaddr = addr - (addr % 4);
    ebe   = '0;
    ewd   = '0;
    for (int b = 0; b < 4; b++) begin
      if (b >= int'(off) && b < int'(off + n)) ebe[b] = 1'b1;
      ewd[8*b +: 8] = wdata[8*(b % int'(n)) +: 8];
    end
    if (we || trap) ersp = '0;
    else if (n == 4) ersp = rdata >> (8 * off);
    else ersp = (rdata >> (8 * off)) & ((32'h1 << (8 * n)) - 1);

    check({nm, ".req_ready_idle"}, req_ready, 1'b1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    if (!trap) begin
      for (int unsigned g = 0; g <= gd; g++) begin
        mem_gnt    = (g == gd);
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        check({nm, ".mem_req"},   mem_req,   1'b1);
        check({nm, ".mem_addr"},  mem_addr,  eaddr);
        check({nm, ".mem_be"},    mem_be,    ebe);
        check({nm, ".mem_we"},    mem_we,    we);
        if (we) check({nm, ".mem_wdata"}, mem_wdata, ewd);
        check({nm, ".req_ready_busy"}, req_ready, 1'b0);
        check({nm, ".rsp_valid_early"}, rsp_valid, 1'b0);
        @(posedge clk); #1;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!we) begin
        for (int unsigned r = 0; r <= rd; r++) begin
          mem_rvalid = (r == rd);
          mem_rdata  = (r == rd) ? rdata : $urandom;
          check({nm, ".mem_req_wait"}, mem_req, 1'b0);
          check({nm, ".rsp_valid_wait"}, rsp_valid, 1'b0);
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
      end
    end else begin
      check({nm, ".no_mem_req"}, mem_req, 1'b0);
    end

    for (int unsigned k = 0; k <= kd; k++) begin
      rsp_ready  = (k == kd);
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      check({nm, ".rsp_valid"},    rsp_valid,    1'b1);
      check({nm, ".rsp_data"},     rsp_data,     ersp);
      check({nm, ".rsp_funct3"},   rsp_funct3,   f3);
      check({nm, ".rsp_misalign"}, rsp_misalign, trap);
      check({nm, ".mem_req_rsp"},  mem_req,      1'b0);
      check({nm, ".req_ready_rsp"}, req_ready,   1'b0);
      @(posedge clk); #1;
    end
    rsp_ready  = 1'b0;
    mem_rvalid = 1'b0;
    check({nm, ".rsp_valid_done"}, rsp_valid, 1'b0);
    check({nm, ".req_ready_done"}, req_ready, 1'b1);
  endtask

  initial begin
    logic [2:0]  f3_list [8];
    logic [2:0]  f3;
    logic [31:0] sext;
    f3_list = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    rsp_ready  = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // Reset values
    check("rst.req_ready",    req_ready,    1'b1);
    check("rst.mem_req",      mem_req,      1'b0);
    check("rst.mem_we",       mem_we,       1'b0);
    check("rst.mem_addr",     mem_addr,     32'h0);
    check("rst.mem_be",       mem_be,       32'h0);
    check("rst.mem_wdata",    mem_wdata,    32'h0);
    check("rst.rsp_valid",    rsp_valid,    1'b0);
    check("rst.rsp_data",     rsp_data,     32'h0);
    check("rst.rsp_funct3",   rsp_funct3,   3'b000);
    check("rst.rsp_misalign", rsp_misalign, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_access("lbu",  1'b0, 3'b100, 32'h103, 32'h0, 32'hFEDCBA98, 0, 0, 0);
    do_access("lh",   1'b0, 3'b001, 32'h202, 32'h0, 32'h80017FFF, 0, 0, 0);
    sext = {{16{rsp_data[15]}}, rsp_data[15:0]};
    check("lh.sext_chain", sext, 32'hFFFF8001);
    do_access("sb",   1'b1, 3'b000, 32'h11, 32'h123456AB, 32'h0, 0, 0, 0);
    do_access("lw_stall", 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 3, 1, 2);
    do_access("lw_mis",   1'b0, 3'b010, 32'h42, 32'h0, 32'h01234567, 0, 0, 0);
    do_access("sh_mis",   1'b1, 3'b001, 32'h33, 32'h0000BEEF, 32'h0, 1, 0, 1);

    // Reset while waiting for read data; the late rvalid must be ignored
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(posedge clk); #1;
    mem_gnt   = 1'b0;
    check("rstwait.in_wait", mem_req, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    check("rstwait.req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rstwait.rsp_valid", rsp_valid, 1'b0);
      check("rstwait.mem_req",   mem_req,   1'b0);
      check("rstwait.req_ready2", req_ready, 1'b1);
      @(posedge clk); #1;
    end

    // Random accesses against the reference model
    for (int i = 0; i < 40; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 7);
      f3  = f3_list[sel];
      do_access($sformatf("rnd%0d", i), (sel >= 5), f3, $urandom, $urandom, $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_align.md
Name: lsu_mem_align

Overview:
Load/store access stage that sits directly upstream of loads_sign_extend. It accepts one load or store request from execute, drives a word-addressed data-memory handshake with byte enables and lane-replicated store data, and waits for read data on loads. It then right-aligns the selected byte, halfword or word to bit 0 and hands it to loads_sign_extend (in, funct3) together with the original funct3. One access is outstanding at a time.

Parameters:
ADDR_WIDTH, 32, byte-address width of req_addr and mem_addr
DATA_WIDTH, 32, data path width; only 32 is supported (4 byte lanes)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  execute presents an access
req_ready  out  1  block can accept an access (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
mem_req  out  1  memory request, held until granted
mem_gnt  in  1  memory accepts request this cycle
mem_we  out  1  write strobe
mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
mem_be  out  4  byte enables
mem_wdata  out  DATA_WIDTH  lane-replicated store data
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_WIDTH  read word
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_data  out  DATA_WIDTH  right-aligned load data, upper unused bits zero; 0 for stores
rsp_funct3  out  3  latched funct3; drives loads_sign_extend.funct3
rsp_misalign  out  1  access was misaligned (see Optional Feature)

Behaviour:
- Reset: state IDLE; req_ready=1; mem_req, mem_we, rsp_valid, rsp_misalign = 0; mem_addr, mem_be, mem_wdata, rsp_data, rsp_funct3 = 0.
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE: req_ready=1. On req_valid, latch we, funct3, addr, wdata; go to REQ (or to RSP if trapped misaligned).
- REQ: mem_req=1; mem_addr, mem_be, mem_we and mem_wdata stay stable until mem_gnt. On mem_gnt, a store goes to RSP and a load goes to WAIT.
- WAIT: mem_req=0. On mem_rvalid, capture the shifted data into rsp_data and go to RSP. mem_rvalid in any other state is ignored.
- RSP: rsp_valid=1 and outputs held stable until rsp_ready; then IDLE. The next req is accepted no earlier than the following cycle.
- Size decode on funct3[1:0]: 00 byte, 01 half, others word. funct3[2]=1 marks unsigned loads; the value passes through unchanged.
- mem_be: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
- mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- rsp_data: (mem_rdata >> 8*addr[1:0]), masked to 8, 16 or 32 bits by size.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Minimum latency: load is accept cycle 0, gnt in cycle 1, rvalid in cycle 2, rsp_valid in cycle 3. Store has rsp_valid in cycle 2. Stalls on gnt, rvalid or rsp_ready extend the respective state indefinitely.
- Reset mid-operation: return to IDLE next edge and drop mem_req. A late mem_rvalid from an aborted load is ignored.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a misaligned access issues no memory request. Go IDLE->RSP with rsp_misalign=1 and rsp_data=0.
- Undefined: low address bits are forced to natural alignment (half clears addr[0]; word clears addr[1:0]) and the access proceeds. rsp_misalign is tied 0.

Decomposition:
- lsu_pkg holds:
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW
  - the size enum (BYTE/HALF/WORD)
  - the FSM state enum
  - function size_of(funct3)
- One combinational sub-module, lsu_lane_align, computes mem_be, mem_wdata, the rdata shift/mask and the misalign flag from (size, addr[1:0], wdata, rdata). The FSM stays in lsu_mem_align.

Test Plan:
- LBU, addr=0x103, mem_rdata=0xFEDCBA98, gnt and rvalid immediate -> mem_addr=0x100, mem_be=1000, rsp_data=0x000000FE, rsp_funct3=100, rsp_valid on cycle 3.
- LH, addr=0x202, rdata=0x8001_7FFF -> mem_be=1100, rsp_data=0x00008001; loads_sign_extend chained gives 0xFFFF8001.
- SB, addr=0x11, wdata=0x123456AB -> mem_we=1, mem_be=0010, mem_wdata=0xABABABAB, rsp_valid on cycle 2, rsp_data=0.
- LW, addr=0x40, mem_gnt withheld 3 cycles and rsp_ready withheld 2 -> mem_req and outputs stable throughout, single response, req_ready low until return to IDLE.
- LW, addr=0x42 -> with LSU_MISALIGN_TRAP_EN: no mem_req, rsp_misalign=1. Without it: mem_addr=0x40, mem_be=1111, rsp_misalign=0.
- rst pulsed in WAIT, then mem_rvalid arrives -> block is in IDLE, rsp_valid stays 0, req_ready=1.
